naive_bus_rr_arbiter: RTL and testbench
=======================================

// Module: naive_bus_rr_arbiter
// PURPOSE
//  Shares one naive_bus slave port between N_MASTER masters, e.g. the instruction-fetch and data bus wrappers.
//  Read and write channels are arbitrated independently with round-robin priority; grant is combinational.
//  Read data returns one cycle after a granted read and is steered back to the owning master only.
// PARAMETERS
//  N_MASTER  2   number of masters, >=2; IW=$clog2(N_MASTER) is the owner-index width
//  AW        32  address width
//  DW        32  data width; byte enables are DW/8 bits wide
// PORTS
//  clk        in   1            clock; all state is on the rising edge
//  rst        in   1            asynchronous reset, active-high
//  m_rd_req   in   N            per-master read request
//  m_rd_be    in   N*DW/8       per-master read byte enables, master i at [i*DW/8 +: DW/8]
//  m_rd_addr  in   N*AW         per-master word-aligned read address
//  m_rd_gnt   out  N            per-master read grant
//  m_rd_data  out  N*DW         per-master read data
//  m_wr_req   in   N            per-master write request
//  m_wr_be    in   N*DW/8       per-master write byte enables
//  m_wr_addr  in   N*AW         per-master write address
//  m_wr_data  in   N*DW         per-master write data
//  m_wr_gnt   out  N            per-master write grant
//  s_rd_req/s_rd_be/s_rd_addr      out  1/DW/8/AW   to slave
//  s_rd_gnt   in   1            slave accepts the read this cycle
//  s_rd_data  in   DW           slave read data, valid the cycle after acceptance
//  s_wr_req/s_wr_be/s_wr_addr/s_wr_data  out  1/DW/8/AW/DW   to slave
//  s_wr_gnt   in   1            slave accepts the write this cycle
// BEHAVIOUR
//  State: rd_ptr, wr_ptr (IW bits, next-highest-priority master), rd_vld_q (1 bit), rd_own_q (IW bits).
//  Reset: all state 0. With no requests, every output is 0; m_rd_data is all 0 in the cycle after reset.
//  Winner: the first requesting master at index rd_ptr, rd_ptr+1, ... modulo N. wr_ptr works the same way.
//  s_rd_req = |m_rd_req. s_rd_be/s_rd_addr = winner's fields, or 0 when there is no request.
//  m_rd_gnt[winner] = s_rd_gnt; all other bits 0. A loser sees req&~gnt and holds its request, per the bus protocol.
//  Pointer update only on s_rd_req&s_rd_gnt: rd_ptr <= (winner==N-1) ? 0 : winner+1.
//  If the slave stalls (gnt=0), the pointer is held, so the same master stays winner.
//  Read return: rd_vld_q <= s_rd_req&s_rd_gnt; rd_own_q <= winner.
//   m_rd_data[i] = (rd_vld_q && rd_own_q==i) ? s_rd_data : 0.
//  Back-to-back reads: a grant in cycle t returns data in t+1 while the grant for t+1 proceeds. Throughput is 1 per cycle.
//  Write channel: same winner/grant/pointer rules using wr_ptr. s_wr_data = winner's data. No return path.
//  Read and write channels are independent:
//   - the same master may win both in one cycle;
//   - masters may win on different channels in the same cycle.
//  Reset mid-operation: a pending read return is dropped (rd_vld_q=0) and the pointers return to 0.
//  Latency: request to slave is 0 cycles (combinational); read data to master is 1 cycle.
// CONFIGURATION
//  NAIVE_ARB_PERF_EN defined:
//   - adds output o_stall_cnt [N*16], master i at [i*16 +: 16];
//   - counter i increments each cycle master i has (m_rd_req[i]&~m_rd_gnt[i]) | (m_wr_req[i]&~m_wr_gnt[i]);
//   - +1 per cycle, saturates at 16'hFFFF, reset to 0.
//  NAIVE_ARB_PERF_EN undefined: no counters and no o_stall_cnt port; arbitration behaviour is identical.
// TESTING
//  1. Reset, then m0 reads 0x100 with s_rd_gnt=1 -> m_rd_gnt=2'b01, s_rd_addr=0x100.
//     Next cycle s_rd_data=0xDEADBEEF -> m_rd_data[0]=0xDEADBEEF, m_rd_data[1]=0.
//  2. m0 and m1 both read continuously, s_rd_gnt=1 -> m_rd_gnt sequence 01,10,01,10.
//     Each master's data appears one cycle after its grant.
//  3. Only m1 requests, s_rd_gnt=0 for 3 cycles -> m_rd_gnt=0, rd_ptr unchanged, m_rd_data all 0.
//     Then gnt=1 -> m_rd_gnt=2'b10 and rd_ptr=0.
//  4. m0 writes 0x55AA to 0x200 (be=4'hF) while m1 reads 0x300, both gnts 1 -> m_wr_gnt=01, m_rd_gnt=10.
//     s_wr_addr=0x200, s_wr_data=0x55AA, s_rd_addr=0x300.
//  5. Pulse rst in the cycle after a granted read from m1 -> m_rd_data all 0, rd_ptr=0.
//     Next dual request -> m0 granted first.
//  6. With NAIVE_ARB_PERF_EN, s_rd_gnt=0 and m1 requesting for 5 cycles -> o_stall_cnt[1]=5, o_stall_cnt[0]=0.
//     After 70000 stalled cycles -> o_stall_cnt[1]=16'hFFFF.

Source files
------------

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave between N_MASTER masters; independent read/write channels.
// Latency: request/grant combinational, read data 1 cycle; slave stalls hold the pointer. NAIVE_ARB_PERF_EN adds stall counters.
module naive_bus_rr_arbiter #(
  parameter int N_MASTER = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTER-1:0]        m_rd_req,
  input  logic [N_MASTER*DW/8-1:0]   m_rd_be,
  input  logic [N_MASTER*AW-1:0]     m_rd_addr,
  output logic [N_MASTER-1:0]        m_rd_gnt,
  output logic [N_MASTER*DW-1:0]     m_rd_data,
  input  logic [N_MASTER-1:0]        m_wr_req,
  input  logic [N_MASTER*DW/8-1:0]   m_wr_be,
  input  logic [N_MASTER*AW-1:0]     m_wr_addr,
  input  logic [N_MASTER*DW-1:0]     m_wr_data,
  output logic [N_MASTER-1:0]        m_wr_gnt,
  output logic                       s_rd_req,
  output logic [DW/8-1:0]            s_rd_be,
  output logic [AW-1:0]              s_rd_addr,
  input  logic                       s_rd_gnt,
  input  logic [DW-1:0]              s_rd_data,
  output logic                       s_wr_req,
  output logic [DW/8-1:0]            s_wr_be,
  output logic [AW-1:0]              s_wr_addr,
  output logic [DW-1:0]              s_wr_data,
  input  logic                       s_wr_gnt
`ifdef NAIVE_ARB_PERF_EN
  ,
  output logic [N_MASTER*16-1:0]     o_stall_cnt
`endif
);

  localparam int IW = $clog2(N_MASTER);
  localparam int BW = DW / 8;

  logic [IW-1:0] rd_ptr, wr_ptr, rd_own_q;
  logic [IW-1:0] rd_win, wr_win;
  logic          rd_vld_q;
  logic          rd_any, wr_any;
  logic          rd_fire, wr_fire;

  // First requester at ptr, ptr+1, ... wrapping; scanned downwards so the lowest offset wins.
  function automatic logic [IW-1:0] rr_pick(input logic [N_MASTER-1:0] req,
                                            input logic [IW-1:0]       ptr);
    logic [IW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (req[IW'(idx)]) pick = IW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] win);
    return (win == IW'(N_MASTER - 1)) ? '0 : win + IW'(1);
  endfunction

  assign rd_any  = |m_rd_req;
  assign wr_any  = |m_wr_req;
  assign rd_win  = rr_pick(m_rd_req, rd_ptr);
  assign wr_win  = rr_pick(m_wr_req, wr_ptr);
  assign rd_fire = rd_any & s_rd_gnt;
  assign wr_fire = wr_any & s_wr_gnt;

  always_comb begin
    s_rd_req  = rd_any;
    s_rd_be   = '0;
    s_rd_addr = '0;
    m_rd_gnt  = '0;
    if (rd_any) begin
      s_rd_be          = m_rd_be[int'(rd_win)*BW +: BW];
      s_rd_addr        = m_rd_addr[int'(rd_win)*AW +: AW];
      m_rd_gnt[rd_win] = s_rd_gnt;
    end
  end

  always_comb begin
    s_wr_req  = wr_any;
    s_wr_be   = '0;
    s_wr_addr = '0;
    s_wr_data = '0;
    m_wr_gnt  = '0;
    if (wr_any) begin
      s_wr_be          = m_wr_be[int'(wr_win)*BW +: BW];
      s_wr_addr        = m_wr_addr[int'(wr_win)*AW +: AW];
      s_wr_data        = m_wr_data[int'(wr_win)*DW +: DW];
      m_wr_gnt[wr_win] = s_wr_gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= '0;
    end else begin
      rd_vld_q <= rd_fire;
      rd_own_q <= rd_win;
      if (rd_fire) rd_ptr <= ptr_after(rd_win);
      if (wr_fire) wr_ptr <= ptr_after(wr_win);
    end
  end

  // Returned data is steered only to the master that owned the accepted read.
  for (genvar i = 0; i < N_MASTER; i++) begin : g_rd_ret
    assign m_rd_data[i*DW +: DW] = (rd_vld_q && rd_own_q == IW'(i)) ? s_rd_data : '0;
  end

`ifdef NAIVE_ARB_PERF_EN
  logic [15:0] stall_cnt [N_MASTER];

  for (genvar i = 0; i < N_MASTER; i++) begin : g_perf
    logic stalled;
    assign stalled = (m_rd_req[i] & ~m_rd_gnt[i]) | (m_wr_req[i] & ~m_wr_gnt[i]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stall_cnt[i] <= '0;
      end else if (stalled && stall_cnt[i] != 16'hFFFF) begin
        stall_cnt[i] <= stall_cnt[i] + 16'd1;
      end
    end

    assign o_stall_cnt[i*16 +: 16] = stall_cnt[i];
  end
`endif

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Directed and random bench for naive_bus_rr_arbiter against a rotating-priority reference model.
module tb_naive_bus_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_rd_req, m_rd_gnt, m_wr_req, m_wr_gnt;
  logic [N*BW-1:0] m_rd_be, m_wr_be;
  logic [N*AW-1:0] m_rd_addr, m_wr_addr;
  logic [N*DW-1:0] m_rd_data, m_wr_data;
  logic            s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
  logic [BW-1:0]   s_rd_be, s_wr_be;
  logic [AW-1:0]   s_rd_addr, s_wr_addr;
  logic [DW-1:0]   s_rd_data, s_wr_data;
`ifdef NAIVE_ARB_PERF_EN
  logic [N*16-1:0] o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mp_rd, mp_wr, mown;
  bit mv;
  int scnt [N];

  naive_bus_rr_arbiter #(.N_MASTER(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m_rd_req(m_rd_req), .m_rd_be(m_rd_be), .m_rd_addr(m_rd_addr),
    .m_rd_gnt(m_rd_gnt), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_be(m_wr_be), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
    .s_rd_req(s_rd_req), .s_rd_be(s_rd_be), .s_rd_addr(s_rd_addr),
    .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_be(s_wr_be), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data), .s_wr_gnt(s_wr_gnt)
`ifdef NAIVE_ARB_PERF_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int win(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (((int'(req) >> ((ptr + k) % N)) & 1) == 1) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    mp_rd = 0; mp_wr = 0; mv = 0; mown = 0;
    for (int i = 0; i < N; i++) scnt[i] = 0;
  endtask

  task automatic idle();
    m_rd_req = '0; m_rd_be = '0; m_rd_addr = '0;
    m_wr_req = '0; m_wr_be = '0; m_wr_addr = '0; m_wr_data = '0;
    s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
  endtask

  // Compare every output with the model for the current cycle's inputs.
  task automatic eval();
    int rw, ww;
    @(negedge clk);
    if (rst) mdl_reset();
    rw = win(m_rd_req, mp_rd);
    ww = win(m_wr_req, mp_wr);
    chk("s_rd_req",  64'(s_rd_req),  64'(rw >= 0));
    chk("s_rd_be",   64'(s_rd_be),   rw >= 0 ? 64'(BW'(m_rd_be >> (rw*BW))) : 64'd0);
    chk("s_rd_addr", 64'(s_rd_addr), rw >= 0 ? 64'(AW'(m_rd_addr >> (rw*AW))) : 64'd0);
    chk("m_rd_gnt",  64'(m_rd_gnt),  (rw >= 0 && s_rd_gnt) ? 64'(1) << rw : 64'd0);
    for (int i = 0; i < N; i++)
      chk("m_rd_data", 64'(m_rd_data[i*DW +: DW]), (mv && mown == i) ? 64'(s_rd_data) : 64'd0);
    chk("s_wr_req",  64'(s_wr_req),  64'(ww >= 0));
    chk("s_wr_be",   64'(s_wr_be),   ww >= 0 ? 64'(BW'(m_wr_be >> (ww*BW))) : 64'd0);
    chk("s_wr_addr", 64'(s_wr_addr), ww >= 0 ? 64'(AW'(m_wr_addr >> (ww*AW))) : 64'd0);
    chk("s_wr_data", 64'(s_wr_data), ww >= 0 ? 64'(DW'(m_wr_data >> (ww*DW))) : 64'd0);
    chk("m_wr_gnt",  64'(m_wr_gnt),  (ww >= 0 && s_wr_gnt) ? 64'(1) << ww : 64'd0);
`ifdef NAIVE_ARB_PERF_EN
    for (int i = 0; i < N; i++)
      chk("stall_cnt", 64'(o_stall_cnt[i*16 +: 16]), 64'(scnt[i]));
`endif
  endtask

  // Advance the model by one clock, then move to just after the edge.
  task automatic adv();
    int  rw, ww;
    bit  st;
    rw = win(m_rd_req, mp_rd);
    ww = win(m_wr_req, mp_wr);
    if (rst) begin
      mdl_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        st = (m_rd_req[i] && !(rw == i && s_rd_gnt)) || (m_wr_req[i] && !(ww == i && s_wr_gnt));
        if (st && scnt[i] < 65535) scnt[i]++;
      end
      mv   = (rw >= 0) && s_rd_gnt;
      mown = rw;
      if (mv) mp_rd = (rw + 1) % N;
      if (ww >= 0 && s_wr_gnt) mp_wr = (ww + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_g [5];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    rst = 1'b1;
    idle();
    mdl_reset();
    eval();
    chk("rst_rd_gnt", 64'(m_rd_gnt), 64'd0);
    chk("rst_s_rd_req", 64'(s_rd_req), 64'd0);
    adv();
    rst = 1'b0;
    eval();
    chk("post_rst_rd_data", 64'(m_rd_data), 64'd0);
    adv();

    // Single read from master 0 and its return
    m_rd_req = 2'b01; m_rd_be = 8'h0F; m_rd_addr[31:0] = 32'h100; s_rd_gnt = 1'b1;
    eval();
    chk("t1_gnt", 64'(m_rd_gnt), 64'h1);
    chk("t1_addr", 64'(s_rd_addr), 64'h100);
    adv();
    idle(); s_rd_data = 32'hDEADBEEF;
    eval();
    chk("t1_data0", 64'(m_rd_data[31:0]), 64'hDEADBEEF);
    chk("t1_data1", 64'(m_rd_data[63:32]), 64'h0);
    adv();

    // Back-to-back alternating reads (a lone m1 grant first brings the pointer to 0)
    m_rd_req = 2'b10; s_rd_gnt = 1'b1;
    eval();
    adv();
    m_rd_req = 2'b11;
    for (int k = 1; k < 5; k++) begin
      s_rd_data = 32'hA000_0000 + 32'(k);
      eval();
      chk("t2_gnt", 64'(m_rd_gnt), 64'(exp_g[k]));
      chk("t2_data", exp_g[k-1] == 2'b01 ? 64'(m_rd_data[31:0]) : 64'(m_rd_data[63:32]),
          64'h0A000_0000 + 64'(k));
      adv();
    end

    // Slave stall with only m1 requesting
    idle();
    eval();
    adv();
    m_rd_req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      s_rd_data = 32'h1111_0000 + 32'(k);
      eval();
      chk("t3_gnt", 64'(m_rd_gnt), 64'h0);
      chk("t3_ptr", 64'(dut.rd_ptr), 64'h0);
      chk("t3_data", 64'(m_rd_data), 64'h0);
      adv();
    end
    s_rd_gnt = 1'b1;
    eval();
    chk("t3_gnt_go", 64'(m_rd_gnt), 64'h2);
    adv();
    idle();
    eval();
    chk("t3_ptr_after", 64'(dut.rd_ptr), 64'h0);
    adv();

    // Concurrent write from m0 and read from m1
    m_wr_req = 2'b01; m_wr_be = 8'h0F; m_wr_addr[31:0] = 32'h200; m_wr_data[31:0] = 32'h55AA;
    m_rd_req = 2'b10; m_rd_addr[63:32] = 32'h300; s_rd_gnt = 1'b1; s_wr_gnt = 1'b1;
    eval();
    chk("t4_wr_gnt", 64'(m_wr_gnt), 64'h1);
    chk("t4_rd_gnt", 64'(m_rd_gnt), 64'h2);
    chk("t4_wr_addr", 64'(s_wr_addr), 64'h200);
    chk("t4_wr_data", 64'(s_wr_data), 64'h55AA);
    chk("t4_wr_be", 64'(s_wr_be), 64'hF);
    chk("t4_rd_addr", 64'(s_rd_addr), 64'h300);
    adv();

    // Reset while m1's read return is pending
    idle(); s_rd_data = 32'hCAFEF00D;
    rst = 1'b1;
    eval();
    chk("t5_data", 64'(m_rd_data), 64'h0);
    chk("t5_rd_ptr", 64'(dut.rd_ptr), 64'h0);
    chk("t5_wr_ptr", 64'(dut.wr_ptr), 64'h0);
    adv();
    rst = 1'b0;
    m_rd_req = 2'b11; m_wr_req = 2'b11; s_rd_gnt = 1'b1; s_wr_gnt = 1'b1;
    eval();
    chk("t5_rd_first", 64'(m_rd_gnt), 64'h1);
    chk("t5_wr_first", 64'(m_wr_gnt), 64'h1);
    adv();

    // Random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      m_rd_req  = N'($urandom);
      m_wr_req  = N'($urandom);
      m_rd_be   = (N*BW)'($urandom);
      m_wr_be   = (N*BW)'($urandom);
      m_rd_addr = {$urandom, $urandom};
      m_wr_addr = {$urandom, $urandom};
      m_wr_data = {$urandom, $urandom};
      s_rd_data = $urandom;
      s_rd_gnt  = ($urandom_range(0, 3) != 0);
      s_wr_gnt  = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      eval();
      adv();
    end
    rst = 1'b0;

`ifdef NAIVE_ARB_PERF_EN
    // Stall counter accumulation and saturation
    idle();
    rst = 1'b1;
    eval();
    adv();
    rst = 1'b0;
    m_rd_req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      eval();
      adv();
    end
    eval();
    chk("t6_cnt1", 64'(o_stall_cnt[31:16]), 64'd5);
    chk("t6_cnt0", 64'(o_stall_cnt[15:0]), 64'd0);
    for (int k = 0; k < 70000; k++) adv();
    eval();
    chk("t6_sat", 64'(o_stall_cnt[31:16]), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
